// File: rtl/bus_arb_pkg.sv
// Shared definitions for the four-master bus arbiter: FSM encoding,
// master count and index width.
package bus_arb_pkg;

    localparam int ARB_MASTERS = 4;
    localparam int MIDX_W      = 2;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_GRANT  = 2'd1;
    localparam logic [1:0] ARB_BUSY   = 2'd2;
    localparam logic [1:0] ARB_REVOKE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ARB_IDLE,
        S_GRANT  = ARB_GRANT,
        S_BUSY   = ARB_BUSY,
        S_REVOKE = ARB_REVOKE
    } arb_state_t;

    function automatic logic [ARB_MASTERS-1:0] idx_mask(input logic [MIDX_W-1:0] idx);
        return {{(ARB_MASTERS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first eligible requester starting at ptr,
// wrapping modulo four.
module rr_pick4 import bus_arb_pkg::*; (
    input  logic [ARB_MASTERS-1:0] req,
    input  logic [MIDX_W-1:0]      ptr,
    input  logic [ARB_MASTERS-1:0] excl,
    output logic [MIDX_W-1:0]      win,
    output logic                   found
);

    logic [ARB_MASTERS-1:0] elig;
    logic [MIDX_W-1:0]      idx;

    assign elig = req & ~excl;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < ARB_MASTERS; i++) begin
            idx = ptr + MIDX_W'(i);
            if (!found && elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_round_robin_arbiter.sv
// Round-robin grant generator for bus masters M0-M3 with a fairness hold
// limit and a transaction watchdog that revokes a hung owner.
module bus_round_robin_arbiter import bus_arb_pkg::*; #(
    parameter int MAX_HOLD    = 64,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ARB_MASTERS-1:0] mReq_,
    input  logic                   sAs_,
    input  logic                   sRdy_,
    output logic [ARB_MASTERS-1:0] mGrnt_,
    output logic [MIDX_W-1:0]      Owner,
    output logic                   OwnerValid,
    output logic                   BusErr,
    output logic [MIDX_W-1:0]      ErrMaster
);

    localparam logic [CNT_W:0] ONE      = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0] HOLD_LIM = (CNT_W+1)'(MAX_HOLD);
    localparam logic [CNT_W:0] WD_LIM   = (CNT_W+1)'(TIMEOUT_CYC);

    arb_state_t             state, state_next;
    logic [MIDX_W-1:0]      ptr, ptr_next;
    logic [CNT_W-1:0]       hold_cnt, hold_next, hold_sat;
    logic [CNT_W-1:0]       wd_cnt, wd_next;
    logic [ARB_MASTERS-1:0] grnt_next;
    logic [MIDX_W-1:0]      owner_next, err_master_next;
    logic                   valid_next, err_next, take_grant;

    logic [ARB_MASTERS-1:0] req, others, excl;
    logic [MIDX_W-1:0]      win;
    logic                   found;
    logic [CNT_W:0]         hold_inc, wd_inc;
    logic                   hold_limit, wd_expire;

    assign req    = ~mReq_;
    assign others = req & ~idx_mask(Owner);
    assign excl   = (state == S_GRANT) ? idx_mask(Owner) : '0;

    // The increments include the cycle that ends at this edge, so the limits
    // trip after exactly MAX_HOLD granted cycles / TIMEOUT_CYC busy cycles.
    assign hold_inc   = {1'b0, hold_cnt} + ONE;
    assign wd_inc     = {1'b0, wd_cnt} + ONE;
    assign hold_sat   = (hold_cnt == '1) ? hold_cnt : hold_inc[CNT_W-1:0];
    assign hold_limit = (MAX_HOLD != 0) && (hold_inc >= HOLD_LIM);
    assign wd_expire  = (wd_inc >= WD_LIM);

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .excl  (excl),
        .win   (win),
        .found (found)
    );

    always_comb begin
        state_next      = state;
        ptr_next        = ptr;
        hold_next       = hold_sat;
        wd_next         = '0;
        grnt_next       = mGrnt_;
        owner_next      = Owner;
        valid_next      = OwnerValid;
        err_next        = 1'b0;
        err_master_next = ErrMaster;
        take_grant      = 1'b0;

        case (state)
            S_IDLE, S_REVOKE: begin
                hold_next = '0;
                if (found) begin
                    take_grant = 1'b1;
                end else begin
                    state_next = S_IDLE;
                    grnt_next  = '1;
                    valid_next = 1'b0;
                end
            end
            S_GRANT: begin
                // A started transaction outranks release and the hold limit.
                if (!sAs_ && sRdy_) begin
                    state_next = S_BUSY;
                end else if (!req[Owner] || (hold_limit && (others != '0))) begin
                    if (found) begin
                        take_grant = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                        grnt_next  = '1;
                        valid_next = 1'b0;
                        hold_next  = '0;
                    end
                end
            end
            S_BUSY: begin
                if (!sRdy_) begin
                    state_next = S_GRANT;
                end else if (wd_expire) begin
                    state_next      = S_REVOKE;
                    err_next        = 1'b1;
                    err_master_next = Owner;
                    grnt_next       = '1;
                    valid_next      = 1'b0;
                    ptr_next        = Owner + 2'd1;
                    hold_next       = '0;
                end else begin
                    wd_next = wd_inc[CNT_W-1:0];
                end
            end
        endcase

        if (take_grant) begin
            state_next = S_GRANT;
            grnt_next  = ~idx_mask(win);
            owner_next = win;
            valid_next = 1'b1;
            ptr_next   = win + 2'd1;
            hold_next  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            hold_cnt   <= '0;
            wd_cnt     <= '0;
            mGrnt_     <= '1;
            Owner      <= '0;
            OwnerValid <= 1'b0;
            BusErr     <= 1'b0;
            ErrMaster  <= '0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            hold_cnt   <= hold_next;
            wd_cnt     <= wd_next;
            mGrnt_     <= grnt_next;
            Owner      <= owner_next;
            OwnerValid <= valid_next;
            BusErr     <= err_next;
            ErrMaster  <= err_master_next;
        end
    end

endmodule

// File: tb/tb_bus_round_robin_arbiter.sv
// Directed bench for bus_round_robin_arbiter: table-driven arbitration vectors
// followed by hand-written hold-limit, watchdog, race and reset sequences.
module tb_bus_round_robin_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] mReq_;
    logic       sAs_;
    logic       sRdy_;
    logic [3:0] mGrnt_;
    logic [1:0] Owner;
    logic       OwnerValid;
    logic       BusErr;
    logic [1:0] ErrMaster;

    int n_chk  = 0;
    int n_fail = 0;

    bus_round_robin_arbiter #(
        .MAX_HOLD    (4),
        .TIMEOUT_CYC (8),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mReq_      (mReq_),
        .sAs_       (sAs_),
        .sRdy_      (sRdy_),
        .mGrnt_     (mGrnt_),
        .Owner      (Owner),
        .OwnerValid (OwnerValid),
        .BusErr     (BusErr),
        .ErrMaster  (ErrMaster)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req_n;
        logic       as_n;
        logic       rdy_n;
        logic [3:0] grnt;
        logic [1:0] owner;
        logic       valid;
    } vec_t;

    vec_t tbl[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    initial begin
        // reset, single request, round-robin order 0,1,2,3,0, then release to idle
        tbl[0] = '{4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1};
        tbl[1] = '{4'b0000, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b1};
        tbl[2] = '{4'b0001, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b1};
        tbl[3] = '{4'b0000, 1'b0, 1'b0, 4'b1101, 2'd1, 1'b1};
        tbl[4] = '{4'b0010, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b1};
        tbl[5] = '{4'b0000, 1'b0, 1'b0, 4'b1011, 2'd2, 1'b1};
        tbl[6] = '{4'b0100, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b1};
        tbl[7] = '{4'b0000, 1'b0, 1'b0, 4'b0111, 2'd3, 1'b1};
        tbl[8] = '{4'b1000, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1};
        tbl[9] = '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0};

        reset = 1'b1;
        mReq_ = 4'b1111;
        sAs_  = 1'b1;
        sRdy_ = 1'b1;
        tick();
        tick();
        chk("reset grant", mGrnt_, 4'b1111);
        chk("reset owner", 4'(Owner), 4'd0);
        chk("reset valid", 4'(OwnerValid), 4'd0);
        chk("reset buserr", 4'(BusErr), 4'd0);
        chk("reset errmaster", 4'(ErrMaster), 4'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            mReq_ = tbl[i].req_n;
            sAs_  = tbl[i].as_n;
            sRdy_ = tbl[i].rdy_n;
            tick();
            chk($sformatf("vec%0d grant", i), mGrnt_, tbl[i].grnt);
            chk($sformatf("vec%0d valid", i), 4'(OwnerValid), 4'(tbl[i].valid));
            if (tbl[i].valid)
                chk($sformatf("vec%0d owner", i), 4'(Owner), 4'(tbl[i].owner));
            chk($sformatf("vec%0d buserr", i), 4'(BusErr), 4'd0);
        end

        // hold limit: M1 grabs the bus, M2 joins one cycle later
        mReq_ = 4'b1101;
        tick();
        chk("hold m1 grant", mGrnt_, 4'b1101);
        mReq_ = 4'b1001;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("hold m1 kept %0d", k), mGrnt_, 4'b1101);
        end
        tick();
        chk("hold handover grant", mGrnt_, 4'b1011);
        chk("hold handover owner", 4'(Owner), 4'd2);
        mReq_ = 4'b1111;
        tick();
        chk("hold idle grant", mGrnt_, 4'b1111);

        // watchdog: M3 starts an access that never completes, M0 waits
        mReq_ = 4'b0111;
        tick();
        chk("wd m3 grant", mGrnt_, 4'b0111);
        mReq_ = 4'b0110;
        sAs_  = 1'b0;
        tick();
        chk("wd busy grant", mGrnt_, 4'b0111);
        sAs_ = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("wd wait grant %0d", k), mGrnt_, 4'b0111);
            chk($sformatf("wd wait buserr %0d", k), 4'(BusErr), 4'd0);
        end
        tick();
        chk("wd abort buserr", 4'(BusErr), 4'd1);
        chk("wd abort errmaster", 4'(ErrMaster), 4'd3);
        chk("wd abort grant", mGrnt_, 4'b1111);
        chk("wd abort valid", 4'(OwnerValid), 4'd0);
        tick();
        chk("wd regrant buserr", 4'(BusErr), 4'd0);
        chk("wd regrant grant", mGrnt_, 4'b1110);
        chk("wd regrant owner", 4'(Owner), 4'd0);

        // race: completion on the watchdog edge
        mReq_ = 4'b0111;
        tick();
        chk("race m3 grant", mGrnt_, 4'b0111);
        sAs_ = 1'b0;
        tick();
        sAs_ = 1'b1;
        for (int k = 1; k <= 7; k++) tick();
        chk("race pre grant", mGrnt_, 4'b0111);
        sRdy_ = 1'b0;
        tick();
        chk("race buserr", 4'(BusErr), 4'd0);
        chk("race grant", mGrnt_, 4'b0111);
        chk("race owner", 4'(Owner), 4'd3);
        chk("race errmaster held", 4'(ErrMaster), 4'd3);
        sRdy_ = 1'b1;
        tick();
        chk("race after buserr", 4'(BusErr), 4'd0);
        chk("race after grant", mGrnt_, 4'b0111);

        // reset while BUSY with M1 owning, which leaves ptr at 2 without reset
        mReq_ = 4'b1101;
        tick();
        chk("rst m1 grant", mGrnt_, 4'b1101);
        sAs_ = 1'b0;
        tick();
        sAs_ = 1'b1;
        tick();
        chk("rst busy grant", mGrnt_, 4'b1101);
        reset = 1'b1;
        tick();
        chk("rst grant", mGrnt_, 4'b1111);
        chk("rst buserr", 4'(BusErr), 4'd0);
        chk("rst valid", 4'(OwnerValid), 4'd0);
        chk("rst errmaster", 4'(ErrMaster), 4'd0);
        reset = 1'b0;
        mReq_ = 4'b0000;
        tick();
        chk("rst 4way grant", mGrnt_, 4'b1110);
        chk("rst 4way owner", 4'(Owner), 4'd0);
        chk("rst 4way buserr", 4'(BusErr), 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
